// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial adder group: FSM encoding and
// the step-counter width calculation.
package adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Counter width for a given number of steps; never narrower than one bit.
  function automatic int clog2(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Also exposes the carry into the top bit, used for signed overflow.
module ripple_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  // The carry is a procedural variable so the chain is a straight ripple
  // with no self-referencing vector.
  always_comb begin : ripple
    logic c;
    c     = c_in;
    sum   = '0;
    c_msb = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb  = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LS chunk
// first, with a registered carry between chunks.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v,
  output state_t           state_dbg
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
      $error("serial_adder: CHUNK must be in 1..WIDTH");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_div
      $error("serial_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
  // a, b, sub and c_in are captured on that edge and ignored afterwards.
  // done pulses for one cycle with s/c_out/v already valid; busy and done
  // are never high together.

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic             carry_q;
  logic [CNT_W-1:0] step_q;

  logic [CHUNK-1:0] sum;
  logic             chunk_co;
  logic             chunk_cmsb;

  ripple_adder #(.CHUNK(CHUNK)) u_ripple (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .c_in  (carry_q),
    .sum   (sum),
    .c_out (chunk_co),
    .c_msb (chunk_cmsb)
  );

  // The accumulator fills from the top so the last chunk lands in the MS bits.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign acc_next = sum;
    end else begin : g_multi
      assign acc_next = {sum, acc_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      c_out   <= 1'b0;
      v       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            step_q  <= '0;
            state_q <= ST_RUN;
            busy    <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= chunk_co;
          acc_q   <= acc_next;
          step_q  <= step_q + 1'b1;
          if (step_q == LAST) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            step_q  <= '0;
            s       <= acc_next;
            c_out   <= chunk_co;
            v       <= chunk_co ^ chunk_cmsb;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule
